// File: rtl/pueo_snap_pkg.sv
// Shared types and constants for the ADC snapshot buffer.
// Imported by the top and the RAM so the beat width is defined once.
package pueo_snap_pkg;

  localparam int SNAP_DATA_BITS = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } snap_state_t;

endpackage : pueo_snap_pkg

// File: rtl/snap_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Written so block RAM is inferred; the output register has a synchronous reset.
module snap_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = pueo_snap_pkg::SNAP_DATA_BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; adding one would prevent block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the same array gives read-first behaviour on collisions.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule : snap_sdp_ram

// File: rtl/axis_snapshot_buffer.sv
// Pre/post-trigger snapshot capture of a 128-bit ADC AXI4-Stream into a circular
// buffer; the frozen record is read back through a registered read port.
module axis_snapshot_buffer
  import pueo_snap_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      aclk,
  input  logic                      arst,
  input  logic [SNAP_DATA_BITS-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      arm_i,
  input  logic                      trig_i,
  input  logic [AW:0]               post_len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [AW-1:0]             trig_addr_o,
  output logic [AW:0]               pre_cnt_o,
  input  logic [AW-1:0]             rd_addr_i,
  output logic [SNAP_DATA_BITS-1:0] rd_data_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  snap_state_t   state, state_next;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill, post_cnt, post_len;
  logic [AW:0]   post_cnt_inc, pre_room, post_len_clamp;
  logic          accept, wr_en, do_arm, do_trig;

  // The block never back-pressures, even while held in reset.
  assign s_axis_tready  = 1'b1;
  assign accept         = s_axis_tvalid;
  assign post_cnt_inc   = post_cnt + 1'b1;
  assign pre_room       = DEPTH_W - post_len;
  assign post_len_clamp = (post_len_i > DEPTH_W) ? DEPTH_W : post_len_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    do_arm     = 1'b0;
    do_trig    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (arm_i) begin
          do_arm     = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (arm_i) begin
          do_arm = 1'b1;
        end else if (trig_i) begin
          do_trig = 1'b1;
          if (post_len == '0) begin
            state_next = DONE;
          end else begin
            // The trigger-cycle beat is post-trigger beat #1.
            wr_en      = accept;
            state_next = (accept && post_len == (AW+1)'(1)) ? DONE : CAPTURE;
          end
        end else begin
          wr_en = accept;
        end
      end
      CAPTURE: begin
        if (arm_i) begin
          do_arm     = 1'b1;
          state_next = ARMED;
        end else begin
          wr_en = accept;
          if (accept && post_cnt_inc == post_len) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      wr_ptr      <= '0;
      fill        <= '0;
      post_cnt    <= '0;
      post_len    <= '0;
      trig_addr_o <= '0;
      pre_cnt_o   <= '0;
    end else begin
      state  <= state_next;
      busy_o <= (state_next == ARMED) || (state_next == CAPTURE);
      done_o <= (state_next == DONE);
      if (do_arm) begin
        wr_ptr   <= '0;
        fill     <= '0;
        post_cnt <= '0;
        post_len <= post_len_clamp;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (wr_en && state == ARMED && fill != DEPTH_W) fill <= fill + 1'b1;
        if (do_trig) begin
          // fill here excludes this cycle's beat, which belongs to the post section.
          trig_addr_o <= wr_ptr;
          pre_cnt_o   <= (fill < pre_room) ? fill : pre_room;
          post_cnt    <= accept ? (AW+1)'(1) : '0;
        end else if (state == CAPTURE && wr_en) begin
          post_cnt <= post_cnt_inc;
        end
      end
    end
  end

  snap_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SNAP_DATA_BITS),
    .AW    (AW)
  ) u_ram (
    .clk   (aclk),
    .rst   (arst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (s_axis_tdata),
    .raddr (rd_addr_i),
    .rdata (rd_data_o)
  );

endmodule : axis_snapshot_buffer

// File: tb/tb_axis_snapshot_buffer.sv
// Directed self-checking bench for axis_snapshot_buffer (DEPTH=512).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_axis_snapshot_buffer;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          aclk = 1'b0;
  logic          arst = 1'b1;
  logic [127:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          arm_i = 1'b0;
  logic          trig_i = 1'b0;
  logic [AW:0]   post_len_i = '0;
  logic          busy_o, done_o;
  logic [AW-1:0] trig_addr_o;
  logic [AW:0]   pre_cnt_o;
  logic [AW-1:0] rd_addr_i = '0;
  logic [127:0]  rd_data_o;

  int n_checks = 0;
  int n_pass   = 0;

  axis_snapshot_buffer #(.DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .arst          (arst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .arm_i         (arm_i),
    .trig_i        (trig_i),
    .post_len_i    (post_len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .trig_addr_o   (trig_addr_o),
    .pre_cnt_o     (pre_cnt_o),
    .rd_addr_i     (rd_addr_i),
    .rd_data_o     (rd_data_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  // Beat payload derived from a counter value; all 128 bits carry information.
  function automatic logic [127:0] beat(input int v);
    logic [31:0] w;
    w = v;
    return {w, ~w, w, ~w};
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic cyc(input bit v, input int val, input bit t, input bit a, input int len = 0);
    s_axis_tvalid = v;
    s_axis_tdata  = v ? beat(val) : '0;
    trig_i        = t;
    arm_i         = a;
    if (a) post_len_i = len[AW:0];
    step();
    s_axis_tvalid = 1'b0;
    trig_i        = 1'b0;
    arm_i         = 1'b0;
  endtask

  task automatic beats(input int start, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, start + i, 1'b0, 1'b0);
  endtask

  task automatic rd_check(input string tag, input int addr, input int val);
    rd_addr_i = addr[AW-1:0];
    step();
    check(tag, rd_data_o, beat(val));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset with tvalid toggling
    arst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = i[0];
      step();
      check("reset_tready", s_axis_tready, 1'b1);
    end
    s_axis_tvalid = 1'b0;
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_trig_addr", trig_addr_o, 0);
    check("reset_pre_cnt", pre_cnt_o, 0);
    check("reset_rd_data", rd_data_o, 0);
    arst = 1'b0;
    step();

    // Trigger in IDLE is ignored
    cyc(1'b1, 9, 1'b1, 1'b0);
    check("idle_trig_busy", busy_o, 1'b0);
    check("idle_trig_done", done_o, 1'b0);
    check("idle_trig_addr", trig_addr_o, 0);

    // Wrap: 1000 pre beats, 100 post
    cyc(1'b0, 0, 1'b0, 1'b1, 100);
    check("wrap_busy_armed", busy_o, 1'b1);
    beats(0, 1000);
    cyc(1'b1, 1000, 1'b1, 1'b0);
    beats(1001, 99);
    check("wrap_done", done_o, 1'b1);
    check("wrap_trig_addr", trig_addr_o, 488);
    check("wrap_pre_cnt", pre_cnt_o, 412);
    cyc(1'b1, 1100, 1'b0, 1'b0);
    rd_check("wrap_oldest_76", 76, 588);
    rd_check("wrap_mem_488", 488, 1000);
    rd_check("wrap_mem_511", 511, 1023);
    rd_check("wrap_mem_0", 0, 1024);
    rd_check("wrap_mem_75", 75, 1099);

    // Basic capture: 50 pre beats, 100 post
    cyc(1'b0, 0, 1'b0, 1'b1, 100);
    check("basic_done_clear", done_o, 1'b0);
    beats(0, 50);
    cyc(1'b1, 50, 1'b1, 1'b0);
    check("basic_busy_capture", busy_o, 1'b1);
    beats(51, 98);
    check("basic_not_done_99", done_o, 1'b0);
    cyc(1'b1, 149, 1'b0, 1'b0);
    check("basic_done", done_o, 1'b1);
    check("basic_busy_low", busy_o, 1'b0);
    beats(150, 2);
    check("basic_trig_addr", trig_addr_o, 50);
    check("basic_pre_cnt", pre_cnt_o, 50);
    rd_check("basic_mem_49", 49, 49);
    rd_check("basic_mem_50", 50, 50);
    rd_check("basic_mem_149", 149, 149);
    rd_check("basic_no_write_150", 150, 662);

    // Gapped valid (1 of 3), trigger on an idle cycle, post_len 4
    cyc(1'b0, 0, 1'b0, 1'b1, 4);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 2000 + i, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0);
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    check("gap_trig_addr", trig_addr_o, 6);
    check("gap_pre_cnt", pre_cnt_o, 6);
    for (int i = 6; i < 9; i++) begin
      cyc(1'b1, 2000 + i, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0);
    end
    check("gap_not_done", done_o, 1'b0);
    check("gap_busy", busy_o, 1'b1);
    cyc(1'b1, 2009, 1'b0, 1'b0);
    check("gap_done", done_o, 1'b1);
    cyc(1'b1, 2010, 1'b0, 1'b0);
    rd_check("gap_mem_0", 0, 2000);
    rd_check("gap_mem_6", 6, 2006);
    rd_check("gap_mem_9", 9, 2009);
    rd_check("gap_no_write_10", 10, 10);

    // post_len 0: trigger goes straight to DONE with no write
    cyc(1'b0, 0, 1'b0, 1'b1, 0);
    beats(3000, 3);
    cyc(1'b1, 3003, 1'b1, 1'b0);
    check("len0_done", done_o, 1'b1);
    check("len0_busy", busy_o, 1'b0);
    check("len0_trig_addr", trig_addr_o, 3);
    check("len0_pre_cnt", pre_cnt_o, 3);
    rd_check("len0_mem_2", 2, 3002);
    rd_check("len0_no_write_3", 3, 2003);

    // post_len 600 clamps to 512: no pre-trigger room
    cyc(1'b0, 0, 1'b0, 1'b1, 600);
    beats(4000, 5);
    cyc(1'b1, 4005, 1'b1, 1'b0);
    check("clamp_pre_cnt", pre_cnt_o, 0);
    check("clamp_trig_addr", trig_addr_o, 5);
    beats(4006, 510);
    check("clamp_not_done", done_o, 1'b0);
    cyc(1'b1, 4516, 1'b0, 1'b0);
    check("clamp_done", done_o, 1'b1);
    rd_check("clamp_mem_5", 5, 4005);
    rd_check("clamp_mem_4", 4, 4516);

    // arm and trig together: arm wins, trigger ignored
    cyc(1'b0, 0, 1'b1, 1'b1, 2);
    check("armtrig_busy", busy_o, 1'b1);
    check("armtrig_done", done_o, 1'b0);
    beats(7000, 3);
    check("armtrig_still_armed", done_o, 1'b0);
    cyc(1'b1, 7003, 1'b1, 1'b0);
    check("armtrig_capture_busy", busy_o, 1'b1);
    cyc(1'b1, 7004, 1'b0, 1'b0);
    check("armtrig_done_after", done_o, 1'b1);
    check("armtrig_trig_addr", trig_addr_o, 3);
    check("armtrig_pre_cnt", pre_cnt_o, 3);

    // Re-arm after 20 post beats
    cyc(1'b0, 0, 1'b0, 1'b1, 100);
    beats(5000, 10);
    cyc(1'b1, 5010, 1'b1, 1'b0);
    beats(5011, 19);
    check("rearm_capture_busy", busy_o, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 30);
    check("rearm_busy", busy_o, 1'b1);
    check("rearm_done", done_o, 1'b0);
    beats(6000, 7);
    cyc(1'b1, 6007, 1'b1, 1'b0);
    beats(6008, 29);
    check("rearm_done_final", done_o, 1'b1);
    check("rearm_trig_addr", trig_addr_o, 7);
    check("rearm_pre_cnt", pre_cnt_o, 7);
    rd_check("rearm_mem_0", 0, 6000);
    rd_check("rearm_mem_7", 7, 6007);
    rd_check("rearm_mem_36", 36, 6036);

    // Reset in the middle of a capture
    cyc(1'b0, 0, 1'b0, 1'b1, 50);
    beats(8000, 5);
    cyc(1'b1, 8005, 1'b1, 1'b0);
    beats(8006, 3);
    arst = 1'b1;
    step();
    arst = 1'b0;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    check("midrst_trig_addr", trig_addr_o, 0);
    check("midrst_pre_cnt", pre_cnt_o, 0);
    check("midrst_rd_data", rd_data_o, 0);
    check("midrst_tready", s_axis_tready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_axis_snapshot_buffer

// File: doc/axis_snapshot_buffer.md
# axis_snapshot_buffer

Pre/post-trigger snapshot capture for one 128-bit ADC AXI4-Stream, sitting directly downstream of a design's `bufN_` output stream. Samples continuously into a circular buffer while armed, freezes a configurable number of beats after a trigger, and exposes the frozen record through a simple registered read port for the control/readout logic. The block never back-pressures the source.

## Interface
- `DEPTH`, 512: buffer depth in 128-bit beats; power of two, 16..4096.
- `AW`, `$clog2(DEPTH)`: address width (derived; do not override).
- `aclk`  in  1  stream and control clock; the only clock.
- `arst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  128  sample beat (8 × 16-bit samples).
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  constant 1, including during reset.
- `arm_i`  in  1  single-cycle pulse: start or restart acquisition.
- `trig_i`  in  1  single-cycle pulse: trigger.
- `post_len_i`  in  AW+1  post-trigger beat count; sampled on `arm_i`.
- `busy_o`  out  1  high in ARMED or CAPTURE.
- `done_o`  out  1  high in DONE.
- `trig_addr_o`  out  AW  buffer address of first post-trigger beat.
- `pre_cnt_o`  out  AW+1  valid pre-trigger beats preceding `trig_addr_o`.
- `rd_addr_i`  in  AW  readout address.
- `rd_data_o`  out  128  readout data, registered.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- A beat is "accepted" on any cycle with `s_axis_tvalid`; beats outside ARMED/CAPTURE are discarded.
- IDLE/DONE + `arm_i` -> ARMED:
  - `wr_ptr`=0, `fill`=0.
  - `post_len` = min(`post_len_i`, DEPTH), latched.
  - `done_o` clears.
- ARMED:
  - Each accepted beat is written at `wr_ptr`; `wr_ptr` increments mod DEPTH (wraps).
  - `fill` increments, saturating at DEPTH.
- ARMED + `trig_i` -> CAPTURE:
  - `trig_addr_o` <= `wr_ptr` as of that cycle.
  - `pre_cnt_o` <= min(`fill`, DEPTH − `post_len`), using `fill` before this cycle's beat.
  - A beat accepted in the trigger cycle is written and is post-trigger beat #1.
  - `post_cnt` starts at 1 if a beat was accepted in the trigger cycle, else 0.
- CAPTURE:
  - Keep writing; `post_cnt` counts accepted beats.
  - When `post_cnt` reaches `post_len` -> DONE. No write occurs after the last post beat.
  - `post_len`=0: trigger -> DONE directly, with no beat written in the trigger cycle.
- DONE: buffer frozen; outputs held until next `arm_i`.
- `arm_i` in ARMED or CAPTURE: restart as above; the partial record is abandoned.
- `arm_i` and `trig_i` in the same cycle: arm wins; trigger ignored.
- `trig_i` in IDLE, DONE or CAPTURE: ignored.
- Readout:
  - `rd_data_o` = mem[`rd_addr_i`] one cycle later.
  - Valid in any state; contents are meaningful in DONE.
  - Read-during-write to the same address returns the old data.
- Record order: oldest beat at (`trig_addr_o` − `pre_cnt_o`) mod DEPTH, proceeding upward with wrap.

## Timing
- Reset values:
  - state=IDLE.
  - `busy_o`=0, `done_o`=0.
  - `trig_addr_o`=0, `pre_cnt_o`=0.
  - `rd_data_o`=0.
  - `s_axis_tready`=1.
  - Internal `wr_ptr`, `fill`, `post_cnt`, `post_len` = 0.
- Memory contents are not reset.
- `arst` mid-capture returns to IDLE next cycle; the record is lost.
- `busy_o`/`done_o` are registered state decodes: the state change is visible the cycle after the causing pulse or beat.
- Write latency: a beat accepted in cycle N is readable with `rd_addr_i` applied in cycle N+1, data out in cycle N+2.
- Read latency: 1 cycle. Throughput: one beat per cycle, no stalls.

## Structure
- Package `pueo_snap_pkg`:
  - `snap_state_t` enum (IDLE, ARMED, CAPTURE, DONE).
  - `SNAP_DATA_BITS`=128.
- Sub-module `snap_sdp_ram`:
  - Simple dual-port RAM: one write port, one registered read port, read-first.
  - Infers BRAM.
  - Parameters DEPTH and width.
  - Output register with synchronous reset.
- FSM, counters and latches live in the top.

## Test plan
- Reset: assert `arst` 3 cycles with tvalid toggling -> `s_axis_tready`=1 throughout; `busy_o`=0, `done_o`=0, `trig_addr_o`=0, `pre_cnt_o`=0.
- Basic capture (DEPTH=512, `post_len_i`=100):
  - Arm, stream counter data 0,1,2… continuously, trigger after 50 beats.
  - Expect `pre_cnt_o`=50, `trig_addr_o`=50.
  - mem[50] = trigger-cycle beat (value 50), mem[149]=149.
  - `done_o` rises after the 100th post beat; no further writes.
- Wrap:
  - `post_len_i`=100, trigger after 1000 continuous beats.
  - Expect `trig_addr_o`=1000 mod 512=488, `pre_cnt_o`=412.
  - Oldest beat at address 76 holds value 588.
  - Post beats 1000..1099 at addresses 488..511, 0..75.
- Gapped valid: tvalid 1-of-3 -> only valid beats stored contiguously; `post_cnt` ignores idle cycles.
- Edges:
  - `post_len_i`=0 -> DONE the cycle after the trigger, no write.
  - `post_len_i`=600 -> clamped to 512, `pre_cnt_o`=0.
  - `arm_i`+`trig_i` same cycle -> ARMED, no trigger.
  - `trig_i` in IDLE -> no change.
- Re-arm mid-CAPTURE: `arm_i` after 20 post beats -> back to ARMED with `wr_ptr`=0, `fill`=0; next trigger yields a fresh record with correct `pre_cnt_o`.
